// File: rtl/mul_pkg.sv
// Shared types and sizing constants for the shift-add multiplier sequencer.
package mul_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/rca_addsub.sv
// WIDTH-bit combinational ripple-carry adder; subtraction is done by the
// caller inverting b and setting Cin.
module rca_addsub
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Overflow
);

  logic [WIDTH:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign S[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign Cout     = c[WIDTH];
  assign Overflow = c[WIDTH] ^ c[WIDTH-1];

endmodule

// File: rtl/shift_add_mul_ctrl.sv
// Multi-cycle shift-add multiplier: one ripple-carry add per clock, WIDTH iterations.
// Define SIGNED_MUL_EN for two's-complement operands via radix-2 Booth recoding.
module shift_add_mul_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   P
);

  localparam int                 CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   p_q, p_d;

  logic [WIDTH-1:0]     add_b;
  logic [WIDTH-1:0]     add_s;
  logic                 add_cin;
  logic                 add_cout;
  logic                 add_ovf;
  logic                 shift_msb;

`ifdef SIGNED_MUL_EN
  logic q1_q, q1_d;
  logic cout_unused;

  assign cout_unused = add_cout;

  // Booth pair {Q[0], q1}: 01 adds M, 10 subtracts M, 00/11 pass acc through.
  always_comb begin
    add_b   = '0;
    add_cin = 1'b0;
    case ({q_q[0], q1_q})
      2'b01: add_b = m_q;
      2'b10: begin
        add_b   = ~m_q;
        add_cin = 1'b1;
      end
      default: begin
        add_b   = '0;
        add_cin = 1'b0;
      end
    endcase
  end

  // Sum MSB corrected by overflow is the true sign, so MIN_INT stays exact.
  assign shift_msb = add_s[WIDTH-1] ^ add_ovf;
`else
  logic ovf_unused;

  assign ovf_unused = add_ovf;
  assign add_b      = q_q[0] ? m_q : '0;
  assign add_cin    = 1'b0;
  assign shift_msb  = add_cout;
`endif

  rca_addsub #(
    .WIDTH(WIDTH)
  ) u_rca (
    .a       (acc_q),
    .b       (add_b),
    .Cin     (add_cin),
    .S       (add_s),
    .Cout    (add_cout),
    .Overflow(add_ovf)
  );

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
`ifdef SIGNED_MUL_EN
    q1_d    = q1_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = A;
          q_d     = B;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef SIGNED_MUL_EN
          q1_d    = 1'b0;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = {shift_msb, add_s[WIDTH-1:1]};
        q_d   = {add_s[0], q_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
`ifdef SIGNED_MUL_EN
        q1_d  = q_q[0];
`endif
        // Final iteration: capture the shifted {acc,Q} directly into P.
        if (cnt_q == CNT_LAST) begin
          p_d     = {shift_msb, add_s, q_q[WIDTH-1:1]};
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
`ifdef SIGNED_MUL_EN
      q1_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
`ifdef SIGNED_MUL_EN
      q1_q    <= q1_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign P    = p_q;

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Scoreboard bench for shift_add_mul_ctrl; directed operand pairs with
// hand-computed products, latency, hold, abort and back-to-back checks.
module tb_shift_add_mul_ctrl;

  localparam int W = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [W-1:0]       A;
  logic [W-1:0]       B;
  logic               busy;
  logic               done;
  logic [2*W-1:0]     P;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  int gap = 0;
  logic prev_done = 1'b0;
  logic [2*W-1:0] exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  shift_add_mul_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .busy (busy),
    .done (done),
    .P    (P)
  );

  task automatic check(input string name, input logic [2*W-1:0] act,
                       input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected product per done pulse.
  initial forever begin
    @(negedge clk);
    if (!rst && done) begin
      done_cnt++;
      gap = cyc - last_done_cyc;
      last_done_cyc = cyc;
      check("done_one_cycle", {63'd0, prev_done}, '0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got P=%h with no expected product", P);
      end else begin
        check("product", P, exp_q.pop_front());
      end
    end
    prev_done = done && !rst;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] e);
    int n;
    @(negedge clk);
    n = 0;
    while (busy && n < 4*W) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("wait_idle", {63'd0, busy}, '0);
    A = a;
    B = b;
    start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Called just after the accept edge (or lat0 edges later).
  task automatic wait_done(input string name, input int lat0);
    int lat;
    lat = lat0;
    for (int i = 0; i < W + 8; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) break;
    end
    check({name, "_latency"}, 64'(lat), 64'(W));
    @(negedge clk);
    check({name, "_idle_after"}, {62'd0, busy, done}, '0);
  endtask

  initial begin
    logic [2*W-1:0] ff_exp;
    logic [2*W-1:0] last_p;
    int d0;
`ifdef SIGNED_MUL_EN
    ff_exp = 64'h0000000000000001;
`else
    ff_exp = 64'hFFFFFFFE00000001;
`endif
    rst = 1'b1;
    start = 1'b1;
    A = 32'd3;
    B = 32'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {63'd0, busy}, '0);
    check("reset_done", {63'd0, done}, '0);
    check("reset_p", P, '0);

    // start already high as reset releases: accept at the first edge.
    exp_q.push_back(64'd15);
    rst = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("mul_3x5", 0);

    issue(32'd0, 32'd12345, 64'd0);
    wait_done("mul_0", 0);

    issue(32'hFFFFFFFF, 32'hFFFFFFFF, ff_exp);
    wait_done("mul_ff", 0);
    last_p = ff_exp;

    // start during RUN must be ignored; P holds the previous result.
    issue(32'd7, 32'd6, 64'd42);
    repeat (4) @(posedge clk);
    #1;
    A = 32'd2;
    B = 32'd2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("p_hold_during_run", P, last_p);
    d0 = done_cnt;
    wait_done("mul_7x6", 5);
    repeat (W + 4) @(negedge clk);
    check("single_done", 64'(done_cnt), 64'(d0 + 1));

    // Asynchronous reset mid-RUN clears outputs immediately.
    issue(32'd9, 32'd9, 64'd81);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", {63'd0, busy}, '0);
    check("abort_done", {63'd0, done}, '0);
    check("abort_p", P, '0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    issue(32'd8, 32'd7, 64'd56);
    wait_done("mul_8x7", 0);

    // start held high: one operation per W+2 cycles.
    @(negedge clk);
    A = 32'd2;
    B = 32'd3;
    start = 1'b1;
    exp_q.push_back(64'd6);
    d0 = done_cnt;
    @(posedge clk);
    #1;
    A = 32'd4;
    B = 32'd5;
    exp_q.push_back(64'd20);
    for (int i = 0; i < 3 * W && done_cnt < d0 + 2; i++) @(negedge clk);
    start = 1'b0;
    check("held_done_count", 64'(done_cnt), 64'(d0 + 2));
    check("held_done_spacing", 64'(gap), 64'(W + 2));

`ifdef SIGNED_MUL_EN
    issue(32'hFFFFFFFD, 32'd5, 64'hFFFFFFFFFFFFFFF1);
    wait_done("smul_m3x5", 0);
    issue(32'h80000000, 32'h80000000, 64'h4000000000000000);
    wait_done("smul_min", 0);
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
